// File: rtl/psram_xfer_sched.sv
// Round-robin transfer scheduler for the PSRAM command engine: splits each granted transfer
// into page-safe, burst-limited segments and issues them one at a time.
`timescale 1ns/1ps
module psram_xfer_sched #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 23,
  parameter int LEN_WIDTH  = 12,
  parameter int PAGE_BYTES = 1024,
  parameter int MAX_BURST  = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0]              req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len_i,
  output logic [NUM_REQ-1:0]              done_o,
  output logic                            cmd_valid_o,
  input  logic                            cmd_ready_i,
  output logic                            cmd_we_o,
  output logic [ADDR_WIDTH-1:0]           cmd_addr_o,
  output logic [$clog2(MAX_BURST)-1:0]    cmd_len_o,
  output logic [$clog2(NUM_REQ)-1:0]      cmd_id_o,
  output logic                            cmd_last_o,
  input  logic                            seg_done_i,
  output logic                            busy_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int SL_W  = $clog2(MAX_BURST);
  localparam int PG_W  = $clog2(PAGE_BYTES);
  localparam int REM_W = LEN_WIDTH + 1;

  // Command handshake: a segment transfers on a cycle with cmd_valid_o && cmd_ready_i; while
  // cmd_valid_o is high and cmd_ready_i low every cmd_* field holds its value.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                state;
  logic [ID_W-1:0]       ptr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [REM_W-1:0]      rem;

  logic                  grant_any;
  logic [ID_W-1:0]       grant_idx;
  logic [31:0]           rem_w;
  logic [31:0]           left_w;
  logic [31:0]           seg_w;

  always_comb begin
    int idx;
    logic [ID_W-1:0] idx_c;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_c     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_c = ID_W'(idx);
      if (!grant_any && req_valid_i[idx_c]) begin
        grant_any = 1'b1;
        grant_idx = idx_c;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state == IDLE && grant_any) req_ready_o[grant_idx] = 1'b1;
  end

  // Segment = min(remaining, burst limit, bytes left in the current page).
  always_comb begin
    rem_w  = 32'(rem);
    left_w = 32'(PAGE_BYTES) - 32'(addr[PG_W-1:0]);
    seg_w  = rem_w;
    if (seg_w > 32'(MAX_BURST)) seg_w = 32'(MAX_BURST);
    if (seg_w > left_w)         seg_w = left_w;
  end

  assign cmd_addr_o = addr;
  assign cmd_len_o  = cmd_valid_o ? SL_W'(seg_w - 32'd1) : '0;
  assign cmd_last_o = cmd_valid_o && (seg_w == rem_w);
  assign busy_o     = (state != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      addr        <= '0;
      rem         <= '0;
      cmd_we_o    <= 1'b0;
      cmd_id_o    <= '0;
      cmd_valid_o <= 1'b0;
      done_o      <= '0;
    end else begin
      done_o <= '0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            cmd_we_o    <= req_we_i[grant_idx];
            addr        <= req_addr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            rem         <= REM_W'(req_len_i[grant_idx*LEN_WIDTH +: LEN_WIDTH]) + REM_W'(1);
            cmd_id_o    <= grant_idx;
            ptr         <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            cmd_valid_o <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (seg_done_i) begin
            addr <= addr + ADDR_WIDTH'(seg_w);
            rem  <= rem - REM_W'(seg_w);
            if (seg_w == rem_w) begin
              done_o[cmd_id_o] <= 1'b1;
              state            <= IDLE;
            end else begin
              cmd_valid_o <= 1'b1;
              state       <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_xfer_sched.sv
// Bench for psram_xfer_sched: random and directed requesters, a randomized engine model,
// and a scoreboard fed from a byte-level segmentation model of each granted transfer.
`timescale 1ns/1ps
module tb_psram_xfer_sched;

  localparam int N    = 2;
  localparam int AW   = 23;
  localparam int LW   = 12;
  localparam int PAGE = 1024;
  localparam int MAXB = 32;
  localparam int SLW  = 5;
  localparam int IDW  = 1;
  localparam int EW   = AW + SLW + IDW + 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_we, done;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic            cmd_valid, cmd_ready, cmd_we, cmd_last, seg_done, busy;
  logic [AW-1:0]   cmd_addr;
  logic [SLW-1:0]  cmd_len;
  logic [IDW-1:0]  cmd_id;

  logic            val_a[N];
  logic            we_a[N];
  logic [AW-1:0]   addr_a[N];
  logic [LW-1:0]   len_a[N];

  logic [EW-1:0]   exp_q[$];
  int              exp_done_q[$];
  int              grant_log[$];
  int              ptr_m = 0, done_id = 0, eng_dly = 0, stall_n = 0, stall_run = 0, seg_cnt = 0;
  bit              busy_m = 0, cv_m = 0, done_due = 0, eng_out = 0, sd_gen = 0, last_acc = 0;
  bit              spur_en = 0, force_acc = 0, stall_chk = 0, prev_stall = 0;
  logic [EW-1:0]   prev_cmd = '0;
  int              checks = 0, fails = 0;

  psram_xfer_sched #(.NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .PAGE_BYTES(PAGE),
                     .MAX_BURST(MAXB)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_len_i(req_len), .done_o(done),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_we_o(cmd_we),
    .cmd_addr_o(cmd_addr), .cmd_len_o(cmd_len), .cmd_id_o(cmd_id), .cmd_last_o(cmd_last),
    .seg_done_i(seg_done), .busy_o(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always_comb begin
    req_valid = '0; req_we = '0; req_addr = '0; req_len = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = val_a[i];
      req_we[i]              = we_a[i];
      req_addr[i*AW +: AW]   = addr_a[i];
      req_len[i*LW +: LW]    = len_a[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_segs(input int id, input bit we, input int a0, input int len);
    int rem, a, seg, left;
    rem = len + 1;
    a   = a0;
    while (rem > 0) begin
      left = PAGE - (a % PAGE);
      seg  = rem;
      if (seg > MAXB) seg = MAXB;
      if (seg > left) seg = left;
      exp_q.push_back({we, IDW'(id), (seg == rem), SLW'(seg - 1), AW'(a)});
      a   = (a + seg) % (1 << AW);
      rem = rem - seg;
    end
  endtask

  task automatic model_reset();
    exp_q.delete(); exp_done_q.delete();
    ptr_m = 0; busy_m = 0; cv_m = 0; done_due = 0; eng_out = 0;
    prev_stall = 0; stall_run = 0; force_acc = 0; stall_n = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic sample();
    logic [EW-1:0] cur, e;
    logic [N-1:0]  exp_ready;
    bit            busy_now, cv_next, accept;
    int            g, j;
    cur      = {cmd_we, cmd_id, cmd_last, cmd_len, cmd_addr};
    busy_now = busy_m;
    check("done", 64'(done), done_due ? (64'd1 << done_id) : 64'd0);
    done_due = 0;
    check("busy", 64'(busy), 64'(busy_m));
    check("cmd_valid", 64'(cmd_valid), 64'(cv_m));
    if (prev_stall) check("cmd_stable", 64'(cur), 64'(prev_cmd));
    accept  = cmd_valid && cmd_ready;
    cv_next = cv_m;
    if (accept) begin
      cv_next = 0;
      if (exp_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL cmd_extra: got segment 0x%0h required none", cur);
      end else begin
        e = exp_q.pop_front();
        check("cmd", 64'(cur), 64'(e));
        last_acc = e[AW+SLW];
      end
      seg_cnt++;
      eng_out = 1;
      eng_dly = $urandom_range(0, 3);
      if (stall_chk) begin
        check("stall_cycles", 64'(stall_run), 64'd5);
        stall_chk = 0;
      end
      stall_run = 0;
    end else if (cmd_valid) begin
      stall_run++;
    end
    prev_stall = cmd_valid && !cmd_ready;
    prev_cmd   = cur;
    if (seg_done && sd_gen) begin
      if (last_acc) begin
        done_due = 1;
        done_id  = exp_done_q.pop_front();
        busy_m   = 0;
      end else begin
        cv_next = 1;
      end
    end
    exp_ready = '0;
    g = -1;
    if (!busy_now) begin
      for (int i = 0; i < N; i++) begin
        j = (ptr_m + i) % N;
        if (g < 0 && req_valid[j]) g = j;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (g >= 0) begin
      push_segs(g, we_a[g], int'(addr_a[g]), int'(len_a[g]));
      exp_done_q.push_back(g);
      grant_log.push_back(g);
      ptr_m   = (g + 1) % N;
      busy_m  = 1;
      cv_next = 1;
    end
    cv_m = cv_next;
  endtask

  // engine model drives on the falling edge; the scoreboard samples 1 ns before the rising edge
  initial begin : monitor
    seg_done  = 1'b0;
    cmd_ready = 1'b0;
    forever begin
      @(negedge clk);
      seg_done = 1'b0;
      sd_gen   = 1'b0;
      if (rst) begin
        model_reset();
        cmd_ready = 1'b0;
      end else begin
        if (eng_out) begin
          if (eng_dly == 0) begin seg_done = 1'b1; sd_gen = 1'b1; eng_out = 0; end
          else eng_dly--;
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
          seg_done = 1'b1;
        end
        if (force_acc) begin
          cmd_ready = 1'b1; force_acc = 0;
        end else if (stall_n > 0 && cmd_valid) begin
          cmd_ready = 1'b0; stall_n--;
          if (stall_n == 0) force_acc = 1;
        end else begin
          cmd_ready = ($urandom_range(0, 3) != 0);
        end
      end
      #4;
      if (!rst) sample();
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [AW-1:0] rand_addr();
    int x;
    case ($urandom_range(0, 3))
      0:       x = int'($urandom_range(0, (1 << AW) - 1));
      1:       x = int'($urandom_range(0, 8190)) * PAGE + PAGE - int'($urandom_range(1, 40));
      2:       x = (1 << AW) - int'($urandom_range(1, 40));
      default: x = int'($urandom_range(0, 4095)) * MAXB;
    endcase
    return AW'(x);
  endfunction

  function automatic logic [LW-1:0] rand_len();
    if ($urandom_range(0, 7) == 0) return LW'($urandom_range(0, 1500));
    return LW'($urandom_range(0, 150));
  endfunction

  task automatic req_run(input int r, input int n, input bit rnd, input bit we,
                         input logic [AW-1:0] a, input logic [LW-1:0] l);
    bit got;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      if (rnd) begin
        we_a[r] = 1'($urandom_range(0, 1)); addr_a[r] = rand_addr(); len_a[r] = rand_len();
      end else begin
        we_a[r] = we; addr_a[r] = a; len_a[r] = l;
      end
      val_a[r] = 1'b1;
      got = 0;
      for (int c = 0; c < 3000 && !got; c++) begin
        #4;
        if (req_ready[r]) got = 1;
        @(negedge clk);
      end
      check($sformatf("req%0d_granted", r), 64'(got), 64'd1);
    end
    val_a[r] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 0;
    for (int c = 0; c < 6000 && !ok; c++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !busy_m && !cv_m && !eng_out && !done_due && !val_a[0] && !val_a[1])
        ok = 1;
    end
    check({tag, "_drained"}, 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_done"},      64'(done),      64'd0);
    check({tag, "_cmd_len"},   64'(cmd_len),   64'd0);
    check({tag, "_cmd_last"},  64'(cmd_last),  64'd0);
    check({tag, "_cmd_addr"},  64'(cmd_addr),  64'd0);
    check({tag, "_cmd_id_we"}, 64'({cmd_id, cmd_we}), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    bit hit;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      val_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = '0; len_a[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    check("reset_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    spur_en = 1;

    seg_cnt = 0;
    req_run(0, 1, 0, 1'b0, 23'h000010, 12'd63);
    wait_idle("t1");
    check("t1_segments", 64'(seg_cnt), 64'd2);

    seg_cnt = 0;
    req_run(1, 1, 0, 1'b1, 23'h0003F0, 12'd31);
    wait_idle("t2");
    check("t2_segments", 64'(seg_cnt), 64'd2);

    grant_log.delete();
    fork
      req_run(0, 2, 0, 1'b0, 23'h000100, 12'd0);
      req_run(1, 2, 0, 1'b1, 23'h000200, 12'd0);
    join
    wait_idle("t3");
    check("t3_grant_count", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4)
      check("t3_grant_order", 64'({grant_log[0][1:0], grant_log[1][1:0], grant_log[2][1:0],
                                   grant_log[3][1:0]}), 64'h11);

    stall_n = 5; stall_chk = 1;
    req_run(0, 1, 0, 1'b0, 23'h000040, 12'd7);
    wait_idle("t4");
    check("t4_stall_checked", 64'(stall_chk), 64'd0);

    seg_cnt = 0;
    req_run(1, 1, 0, 1'b0, 23'h7FFFF8, 12'd15);
    wait_idle("t5");
    check("t5_segments", 64'(seg_cnt), 64'd2);

    seg_cnt = 0;
    req_run(0, 1, 0, 1'b1, 23'h000001, 12'd4095);
    wait_idle("tmax");
    check("tmax_segments", 64'(seg_cnt), 64'd129);

    fork
      req_run(0, 12, 1, 1'b0, '0, '0);
      req_run(1, 12, 1, 1'b0, '0, '0);
    join
    wait_idle("rand");

    req_run(0, 1, 0, 1'b0, 23'h002000, 12'd255);
    hit = 0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      #1;
      if (busy && !cmd_valid) hit = 1;
    end
    check("t6_reached_wait", 64'(hit), 64'd1);
    #1 rst = 1'b1;
    #1;
    check_reset("t6_midrst");
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    grant_log.delete();
    fork
      req_run(0, 1, 0, 1'b0, 23'h000080, 12'd0);
      req_run(1, 1, 0, 1'b1, 23'h0000C0, 12'd0);
    join
    wait_idle("t6");
    check("t6_grant_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) check("t6_first_grant", 64'(grant_log[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
